// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: shifting record of in-flight register writes that resolves
// each read port to forward, fall through to the GRF, or stall the D stage.

module fwd_port #(
   parameter int DW     = 32,
   parameter int RW     = 5,
   parameter int STAGES = 3,
   parameter int TW     = 2
) (
   input  logic [STAGES-1:0]         vld,
   input  logic [STAGES-1:0][RW-1:0] a3,
   input  logic [STAGES-1:0][TW-1:0] tnew,
   input  logic [STAGES-1:0][DW-1:0] stage_data,
   input  logic [RW-1:0]             rd_addr,
   input  logic [TW-1:0]             rd_tuse,
   input  logic [DW-1:0]             rf_data,
   output logic [DW-1:0]             fwd_data,
   output logic                      fwd_hit,
   output logic                      stall_req
);

   logic found;

   // Scan from the youngest stage; the first match shadows every older one.
   always_comb begin
      fwd_data  = rf_data;
      fwd_hit   = 1'b0;
      stall_req = 1'b0;
      found     = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         if (!found && vld[k] && (a3[k] == rd_addr) && (rd_addr != '0)) begin
            found = 1'b1;
            if (tnew[k] == '0) begin
               fwd_data = stage_data[k];
               fwd_hit  = 1'b1;
            end else if (tnew[k] > rd_tuse) begin
               stall_req = 1'b1;
            end
         end
      end
   end

endmodule

module fwd_scoreboard #(
   parameter int DW     = 32,
   parameter int RW     = 5,
   parameter int STAGES = 3,
   parameter int RPORTS = 2,
   parameter int TW     = 2,
   parameter int CW     = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      issue_valid,
   input  logic [RW-1:0]             issue_a3,
   input  logic [TW-1:0]             issue_tnew,
   input  logic                      flush,
   input  logic [STAGES-1:0][DW-1:0] stage_data,
   input  logic [RPORTS-1:0][RW-1:0] rd_addr,
   input  logic [RPORTS-1:0][TW-1:0] rd_tuse,
   input  logic [RPORTS-1:0][DW-1:0] rf_data,
   output logic [RPORTS-1:0][DW-1:0] fwd_data,
   output logic [RPORTS-1:0]         fwd_hit,
   output logic                      stall,
   output logic [CW-1:0]             stall_cnt
);

   logic [STAGES-1:0]         vld_pipe;
   logic [STAGES-1:0][RW-1:0] ent_a3;
   logic [STAGES-1:0][TW-1:0] ent_tnew;
   logic [RPORTS-1:0]         stall_req;

   // A stalled cycle injects a bubble at E while older entries keep advancing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
         ent_a3   <= '0;
         ent_tnew <= '0;
      end else if (flush) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= issue_valid & ~stall & (issue_a3 != '0);
         ent_a3[0]   <= issue_a3;
         ent_tnew[0] <= issue_tnew;
         for (int k = 1; k < STAGES; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            ent_a3[k]   <= ent_a3[k-1];
            ent_tnew[k] <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TW'(1);
         end
      end
   end

   for (genvar p = 0; p < RPORTS; p++) begin : g_port
      fwd_port #(
         .DW(DW), .RW(RW), .STAGES(STAGES), .TW(TW)
      ) u_port (
         .vld        (vld_pipe),
         .a3         (ent_a3),
         .tnew       (ent_tnew),
         .stage_data (stage_data),
         .rd_addr    (rd_addr[p]),
         .rd_tuse    (rd_tuse[p]),
         .rf_data    (rf_data[p]),
         .fwd_data   (fwd_data[p]),
         .fwd_hit    (fwd_hit[p]),
         .stall_req  (stall_req[p])
      );
   end

   assign stall = |stall_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if (stall && !flush && (stall_cnt != '1))
         stall_cnt <= stall_cnt + CW'(1);
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: issue-time model of in-flight writes checked every cycle,
// plus directed scenarios with literal expectations.

module tb_fwd_scoreboard;
   localparam int DW = 32, RW = 5, STAGES = 3, RPORTS = 2, TW = 2;

   logic clk = 1'b0;
   logic reset, issue_valid, flush;
   logic [RW-1:0]          issue_a3;
   logic [TW-1:0]          issue_tnew;
   logic [STAGES*DW-1:0]   stage_data;
   logic [RPORTS*RW-1:0]   rd_addr;
   logic [RPORTS*TW-1:0]   rd_tuse;
   logic [RPORTS*DW-1:0]   rf_data, fwd_data, fwd_data2;
   logic [RPORTS-1:0]      fwd_hit, fwd_hit2;
   logic                   stall, stall2;
   logic [15:0]            stall_cnt;
   logic [1:0]             stall_cnt2;

   always #5 clk = ~clk;

   fwd_scoreboard #(.DW(DW), .RW(RW), .STAGES(STAGES), .RPORTS(RPORTS), .TW(TW), .CW(16)) dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_a3(issue_a3),
      .issue_tnew(issue_tnew), .flush(flush), .stage_data(stage_data), .rd_addr(rd_addr),
      .rd_tuse(rd_tuse), .rf_data(rf_data), .fwd_data(fwd_data), .fwd_hit(fwd_hit),
      .stall(stall), .stall_cnt(stall_cnt));

   fwd_scoreboard #(.DW(DW), .RW(RW), .STAGES(STAGES), .RPORTS(RPORTS), .TW(TW), .CW(2)) dut2 (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_a3(issue_a3),
      .issue_tnew(issue_tnew), .flush(flush), .stage_data(stage_data), .rd_addr(rd_addr),
      .rd_tuse(rd_tuse), .rf_data(rf_data), .fwd_data(fwd_data2), .fwd_hit(fwd_hit2),
      .stall(stall2), .stall_cnt(stall_cnt2));

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: list of issued writes stamped with the edge they entered E on.
   typedef struct {int a3; int tnew; int cyc;} rec_t;
   rec_t q[$];
   int cyc = 0;
   int m_cnt = 0, m_cnt2 = 0;

   task automatic model_eval(output logic [RPORTS*DW-1:0] d, output logic [RPORTS-1:0] h,
                             output logic s);
      s = 1'b0;
      h = '0;
      d = rf_data;
      for (int p = 0; p < RPORTS; p++) begin
         int ra, tu, idx, age, tn;
         ra  = int'(rd_addr[p*RW +: RW]);
         tu  = int'(rd_tuse[p*TW +: TW]);
         idx = -1;
         for (int i = 0; i < q.size(); i++)
            if (q[i].a3 == ra && ra != 0) idx = i;
         if (idx >= 0) begin
            age = cyc - q[idx].cyc;
            tn  = q[idx].tnew - age;
            if (tn < 0) tn = 0;
            if (tn == 0) begin
               d[p*DW +: DW] = stage_data[age*DW +: DW];
               h[p] = 1'b1;
            end else if (tn > tu) begin
               s = 1'b1;
            end
         end
      end
   endtask

   logic [RPORTS*DW-1:0] md;
   logic [RPORTS-1:0]    mh;
   logic                 ms;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         m_cnt  = 0;
         m_cnt2 = 0;
      end else begin
         model_eval(md, mh, ms);
         if (flush) begin
            q.delete();
         end else begin
            if (ms) begin
               if (m_cnt < 65535) m_cnt++;
               if (m_cnt2 < 3) m_cnt2++;
            end
            cyc++;
            while (q.size() > 0 && (cyc - q[0].cyc) >= STAGES) void'(q.pop_front());
            if (issue_valid && !ms && issue_a3 != 0)
               q.push_back('{int'(issue_a3), int'(issue_tnew), cyc});
         end
      end
   end

   logic [RPORTS*DW-1:0] cd;
   logic [RPORTS-1:0]    ch;
   logic                 cs;

   always @(negedge clk) begin
      model_eval(cd, ch, cs);
      check("cyc_fwd_data", 64'(fwd_data), 64'(cd));
      check("cyc_fwd_hit", 64'(fwd_hit), 64'(ch));
      check("cyc_stall", 64'(stall), 64'(cs));
      check("cyc_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      check("cyc_stall_cnt_cw2", 64'(stall_cnt2), 64'(m_cnt2));
      check("cyc_stall_cw2", 64'(stall2), 64'(cs));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_rd();
      rd_addr = '0;
      rd_tuse = '0;
   endtask

   task automatic issue(input int a3, input int tn);
      issue_valid = 1'b1;
      issue_a3    = RW'(a3);
      issue_tnew  = TW'(tn);
   endtask

   logic [1:0] sat_exp [5];

   initial begin
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      reset = 1'b1; issue_valid = 1'b0; issue_a3 = '0; issue_tnew = '0; flush = 1'b0;
      stage_data = '0; rf_data = '0; clr_rd();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("init_stall", 64'(stall), 64'(0));
      check("init_cnt", 64'(stall_cnt), 64'(0));

      // ALU RAW hazard
      issue(8, 1);
      tick();
      issue_valid = 1'b0;
      rd_addr[0 +: RW] = 5'd8;
      #1 check("alu_stall", 64'(stall), 64'(1));
      tick();
      stage_data[1*DW +: DW] = 32'hCAFE;
      #1;
      check("alu_fwd", 64'(fwd_data[0 +: DW]), 64'h0000CAFE);
      check("alu_hit", 64'(fwd_hit[0]), 64'(1));
      check("alu_nostall", 64'(stall), 64'(0));
      check("alu_cnt", 64'(stall_cnt), 64'(1));

      // Load-use
      clr_rd();
      issue(9, 2);
      tick();
      issue_valid = 1'b0;
      rd_addr[RW +: RW] = 5'd9;
      rd_tuse[TW +: TW] = 2'd1;
      rf_data[DW +: DW] = 32'h0000_0099;
      #1 check("ld_stall", 64'(stall), 64'(1));
      tick();
      check("ld_wait_stall", 64'(stall), 64'(0));
      check("ld_wait_hit", 64'(fwd_hit[1]), 64'(0));
      check("ld_wait_data", 64'(fwd_data[DW +: DW]), 64'h99);
      tick();
      stage_data[2*DW +: DW] = 32'h0000_BEEF;
      #1;
      check("ld_fwd", 64'(fwd_data[DW +: DW]), 64'hBEEF);
      check("ld_hit", 64'(fwd_hit[1]), 64'(1));
      check("ld_cnt", 64'(stall_cnt), 64'(2));

      // Priority: youngest producer wins
      clr_rd();
      issue(10, 0); tick();
      issue(11, 0); tick();
      issue(10, 0); tick();
      issue_valid = 1'b0;
      rd_addr[0 +: RW] = 5'd10;
      stage_data[0 +: DW]      = 32'hA;
      stage_data[2*DW +: DW]   = 32'hB;
      #1;
      check("prio_fwd", 64'(fwd_data[0 +: DW]), 64'hA);
      check("prio_hit", 64'(fwd_hit[0]), 64'(1));

      // Register 0 never tracked
      clr_rd();
      issue(0, 0); tick();
      issue_valid = 1'b0;
      rf_data[0 +: DW] = 32'h55;
      #1;
      check("r0_hit", 64'(fwd_hit[0]), 64'(0));
      check("r0_data", 64'(fwd_data[0 +: DW]), 64'h55);

      // Flush while stalled, with a competing issue
      clr_rd();
      issue(12, 3); tick();
      issue(13, 1);
      flush = 1'b1;
      rd_addr[0 +: RW] = 5'd12;
      #1 check("fl_pre_stall", 64'(stall), 64'(1));
      tick();
      flush = 1'b0; issue_valid = 1'b0;
      rd_addr[RW +: RW] = 5'd13;
      #1;
      check("fl_stall", 64'(stall), 64'(0));
      check("fl_hit", 64'(fwd_hit), 64'(0));
      check("fl_cnt", 64'(stall_cnt), 64'(2));
      check("fl_cnt_cw2", 64'(stall_cnt2), 64'(2));

      // Asynchronous reset with live entries
      clr_rd();
      issue(5, 0); tick();
      issue(6, 3); tick();
      issue(7, 0); tick();
      issue_valid = 1'b0;
      rd_addr[0 +: RW]  = 5'd5;
      rd_addr[RW +: RW] = 5'd6;
      rf_data[0 +: DW]  = 32'h1234;
      stage_data[2*DW +: DW] = 32'h7777;
      #1;
      check("rst_pre_stall", 64'(stall), 64'(1));
      check("rst_pre_fwd", 64'(fwd_data[0 +: DW]), 64'h7777);
      #2 reset = 1'b1;
      #1;
      check("rst_stall", 64'(stall), 64'(0));
      check("rst_hit", 64'(fwd_hit), 64'(0));
      check("rst_cnt", 64'(stall_cnt), 64'(0));
      check("rst_fwd", 64'(fwd_data[0 +: DW]), 64'h1234);
      @(posedge clk);
      #1 reset = 1'b0;
      clr_rd();

      // Counter saturation on the CW=2 instance
      for (int i = 0; i < 5; i++) begin
         clr_rd();
         issue(20, 1); tick();
         issue_valid = 1'b0;
         rd_addr[0 +: RW] = 5'd20;
         #1 check("sat_stall", 64'(stall), 64'(1));
         tick();
         check("sat_cnt_cw2", 64'(stall_cnt2), 64'(sat_exp[i]));
         check("sat_cnt_cw16", 64'(stall_cnt), 64'(i + 1));
      end
      clr_rd();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the fixed 2/3-input forwarding muxes of the P7 pipeline.
- Keeps a shifting record of in-flight register writes: destination, validity and Tnew countdown, one entry per tracked stage (stage 0 = E, youngest).
- For each read port, picks the youngest matching producer and either forwards that stage's data or asserts stall; also keeps a saturating stall-cycle counter.
- Sits beside the D-stage decoder; replaces the per-site HMUX instances and the separate stall logic.

Parameters:
DW, 32, data width
RW, 5, register address width
STAGES, 3, tracked producer stages (index 0 = E, STAGES-1 = W)
RPORTS, 2, read ports
TW, 2, width of Tnew/Tuse fields
CW, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
issue_valid  in  1  D-stage instruction writes a register and wants to enter E
issue_a3  in  RW  destination register of issuing instruction
issue_tnew  in  TW  cycles until its result exists, counted from E entry
flush  in  1  kill all tracked entries (exception/eret)
stage_data  in  STAGES*DW  result value available at each stage; slice k = stage k
rd_addr  in  RPORTS*RW  source register per port
rd_tuse  in  RPORTS*TW  cycles until the consumer needs the value
rf_data  in  RPORTS*DW  GRF read data per port
fwd_data  out  RPORTS*DW  forwarded or GRF value per port
fwd_hit  out  RPORTS  1 = port p is forwarded from a stage
stall  out  1  D must hold; a bubble enters E
stall_cnt  out  CW  saturating count of stall cycles

Behaviour:
Entry state:
- Each entry k holds valid, a3 and tnew.
Reset (async, immediate):
- All entries valid=0; stall_cnt=0.
- Consequently stall=0, fwd_hit=0, fwd_data=rf_data.
Every rising edge without reset, the whole record shifts:
- Entry k+1 <= entry k, with tnew decremented, saturating at 0.
- Entry STAGES-1 is discarded (retired).
- Entry 0 <= {issue_valid & ~stall & (issue_a3!=0), issue_a3, issue_tnew}.
- A stalled cycle therefore loads a bubble into entry 0; older entries always advance.
Flush:
- Takes priority over issue and shift: every entry valid=0 at that edge.
- stall_cnt holds on a flush cycle.
Match, per port p:
- An entry matches when valid=1, a3==rd_addr[p] and rd_addr[p]!=0.
- The youngest (lowest-index) match governs; older matches are ignored.
Resolution, per port, combinational on current state:
- No match: fwd_data=rf_data, fwd_hit=0.
- Match with tnew==0: fwd_data=stage_data[k], fwd_hit=1.
- Match with 0<tnew<=tuse: fwd_data=rf_data, fwd_hit=0, no stall; a later stage forwards.
- Match with tnew>tuse: port requests stall.
- stall = OR of all port requests. fwd_data is still driven per the rules above but is don't-care to the consumer.
stall_cnt:
- +1 on each edge where stall=1 and flush=0.
- Saturates at 2^CW-1, never wraps.
Register 0:
- Never tracked; an issue with a3=0 loads an invalid entry.
Simultaneous events:
- Issue and retire in the same cycle are independent.
- A port matching a retiring entry W still forwards this cycle.
Timing:
- No latency on fwd_data or stall: both are purely combinational from registered state and current inputs.

Test Plan:
- Reset: assert reset mid-run with 3 valid entries -> immediately stall=0, fwd_hit=0, stall_cnt=0; rf_data=0x1234 on rd_addr=5 gives fwd_data=0x1234.
- ALU RAW hazard: issue a3=8, tnew=1; next cycle read $8 with tuse=0 -> stall=1 for one cycle. Following cycle the entry is at stage 1 with tnew=0; stage_data[1]=0xCAFE -> fwd_data=0xCAFE, fwd_hit=1, stall=0, stall_cnt=1.
- Load-use: issue a3=9, tnew=2; read $9 with tuse=1 -> stall=1 one cycle. Next cycle (stage 1, tnew=1) -> stall=0, fwd_hit=0. Next cycle (stage 2, tnew=0) -> forward stage_data[2].
- Priority: stage 0 and stage 2 both write $10 with tnew=0, stage_data 0xA and 0xB -> fwd_data=0xA. Separately, issue a3=0 with rd_addr=0 -> fwd_hit=0, fwd_data=rf_data.
- Flush: flush=1 and issue_valid=1 on the same edge while stalled -> all entries cleared, stall=0 the next cycle, stall_cnt unchanged.
- Counter saturation (CW=2): hold a stall for 5 cycles -> stall_cnt reads 1, 2, 3, 3, 3.
